auto_gain_control: RTL
======================

Name: auto_gain_control

Overview:
- Closed-loop AGC that replaces the button-driven gain source in the receiver chain.
- Consumes the filter-chain output stream (32-bit signed samples with valid) and measures windowed peak magnitude.
- Issues gain_dB / set_gain requests to the AFE control block (PGA + HGA) to keep signal peaks inside a target band.
- Sits in the filter-chain clock domain; the integrator provides any CDC to the AFE domain.

Parameters:
WINDOW_LEN, 4096, valid samples per measurement window (>=2)
SETTLE_LEN, 256, valid samples discarded after each gain change (>=1)
HIGH_THRESH, 32'h2000_0000, window peak above this -> reduce gain
LOW_THRESH, 32'h0400_0000, window peak below this -> raise gain (must be < HIGH_THRESH)
CLIP_THRESH, 32'h7000_0000, any single sample magnitude >= this -> immediate gain reduction
GAIN_MIN, -16, minimum gain in dB
GAIN_MAX, 44, maximum gain in dB
GAIN_STEP, 4, gain change per adjustment in dB
INIT_GAIN, 0, gain applied after reset

Ports:
clk  input  1  clock (filter-chain domain)
rst  input  1  synchronous active-high reset
en_i  input  1  AGC enable; low freezes gain
data_i  input  32  signed filtered sample
valid_i  input  1  data_i qualifier, one-cycle strobes
afe_busy_i  input  1  AFE gain set in progress
gain_dB_o  output  8  signed requested gain in dB
set_gain_o  output  1  one-cycle request strobe
peak_o  output  32  unsigned peak of the last completed window
locked_o  output  1  last completed window was inside [LOW_THRESH, HIGH_THRESH]

Behaviour:
- Reset values:
  - gain_dB_o = INIT_GAIN; set_gain_o = 0; peak_o = 0; locked_o = 0.
  - Window counter and peak accumulator cleared; state = REQUEST.
  - Reset mid-operation aborts everything and returns to these values.
- Magnitude: mag = |data_i| as unsigned 32-bit. data_i = 0x8000_0000 saturates to 0x7FFF_FFFF.
- State REQUEST:
  - Asserts set_gain_o for exactly 1 cycle with gain_dB_o stable.
  - Next state WAIT_BUSY.
- State WAIT_BUSY:
  - Stays while afe_busy_i = 1, and for at least 1 cycle after REQUEST so the AFE can raise busy.
  - Next state SETTLE.
- State SETTLE:
  - Counts valid_i strobes; samples are ignored.
  - After SETTLE_LEN strobes, clears peak and count and goes to MEASURE.
- State MEASURE:
  - On each valid_i: peak <= max(peak, mag); count increments.
  - Clip: if mag >= CLIP_THRESH and gain_dB_o > GAIN_MIN, apply gain_dB_o <= max(gain_dB_o - GAIN_STEP, GAIN_MIN) on the following cycle. Then peak_o <= mag, locked_o <= 0, and go to REQUEST. The window is abandoned.
  - Clip at GAIN_MIN: continue the window normally.
  - Window complete: on the WINDOW_LEN-th valid, the final peak includes that sample. peak_o is updated one cycle later, with the decision in the same cycle:
    - peak > HIGH_THRESH and gain > GAIN_MIN: gain - GAIN_STEP (clamped), locked_o = 0, go to REQUEST.
    - peak < LOW_THRESH and gain < GAIN_MAX: gain + GAIN_STEP (clamped), locked_o = 0, go to REQUEST.
    - Otherwise (in band, or at the clamp limit): gain unchanged, locked_o = 1 only if in band, no request, restart MEASURE with a cleared window.
- Latency: window-final valid -> set_gain_o high in 2 cycles. Clip sample valid -> set_gain_o high in 2 cycles.
- Disabled (en_i = 0):
  - From MEASURE or SETTLE: go to HOLD, where valid_i is ignored, gain is held and no requests are issued.
  - From REQUEST or WAIT_BUSY: the in-flight request completes first, then HOLD.
  - en_i rising from HOLD: go to SETTLE (a new request is not needed).
- Gain arithmetic: signed 8-bit; clamping is done before the register update; gain_dB_o is never outside [GAIN_MIN, GAIN_MAX].
- afe_busy_i high while in MEASURE: samples are still accumulated; no special action.
- Decisions are made only in MEASURE; exactly one set_gain_o pulse per decision.

Test Plan:
- Bench params: WINDOW_LEN=8, SETTLE_LEN=4, HIGH=1000, LOW=100, CLIP=5000, INIT_GAIN=0.
- Reset release, afe_busy_i=0 -> set_gain_o single pulse with gain_dB_o=0 within 2 cycles; peak_o=0, locked_o=0.
- Settle 4 valids, then 8 valids of ±50 -> peak_o=50, gain_dB_o=4, one set_gain_o; repeat until gain_dB_o=44, after which further low windows give no pulse and locked_o=0.
- At gain 20, window containing -2000 (all others 10) -> peak_o=2000, gain_dB_o=16; constant ±500 windows -> locked_o=1, no pulses.
- At gain 20, single sample 6000 as 3rd valid of window -> set_gain_o 2 cycles later, gain_dB_o=16, window abandoned; sample 0x8000_0000 -> treated as clip, mag 0x7FFF_FFFF.
- afe_busy_i held high 20 cycles after a pulse -> no SETTLE counting until busy falls; then exactly 4 valids discarded.
- en_i dropped mid-window -> no pulses, gain frozen; re-enable -> 4 valids discarded then fresh 8-sample window; rst asserted mid-SETTLE -> outputs to reset values, new INIT pulse.

Source files
------------

// File: rtl/auto_gain_control.sv
// Closed-loop automatic gain control: measures windowed peak magnitude of the
// filter-chain stream and requests PGA/HGA gain steps to keep peaks in band.
module auto_gain_control #(
  parameter int          WINDOW_LEN  = 4096,
  parameter int          SETTLE_LEN  = 256,
  parameter logic [31:0] HIGH_THRESH = 32'h2000_0000,
  parameter logic [31:0] LOW_THRESH  = 32'h0400_0000,
  parameter logic [31:0] CLIP_THRESH = 32'h7000_0000,
  parameter int          GAIN_MIN    = -16,
  parameter int          GAIN_MAX    = 44,
  parameter int          GAIN_STEP   = 4,
  parameter int          INIT_GAIN   = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en_i,
  input  logic [31:0] data_i,
  input  logic        valid_i,
  input  logic        afe_busy_i,
  output logic [7:0]  gain_dB_o,
  output logic        set_gain_o,
  output logic [31:0] peak_o,
  output logic        locked_o
);

  // Handshakes: valid_i qualifies data_i for exactly the cycle it is high and
  // there is no backpressure; set_gain_o is a one-cycle strobe with gain_dB_o
  // stable, and afe_busy_i holds the loop in WAIT_BUSY until the AFE is done.
  typedef enum logic [2:0] {
    ST_REQUEST,
    ST_WAIT_BUSY,
    ST_SETTLE,
    ST_MEASURE,
    ST_DECIDE,
    ST_HOLD
  } state_t;

  localparam int CNT_MAX = (WINDOW_LEN > SETTLE_LEN) ? WINDOW_LEN : SETTLE_LEN;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0]  WIN_LAST = CNT_W'(WINDOW_LEN - 1);
  localparam logic [CNT_W-1:0]  SET_LAST = CNT_W'(SETTLE_LEN - 1);
  localparam logic signed [8:0] MIN9     = 9'(GAIN_MIN);
  localparam logic signed [8:0] MAX9     = 9'(GAIN_MAX);
  localparam logic signed [8:0] STEP9    = 9'(GAIN_STEP);
  localparam logic [7:0]        INIT8    = 8'(INIT_GAIN);

  state_t            state_q, state_n;
  logic [CNT_W-1:0]  cnt_q, cnt_n;
  logic [31:0]       peak_acc_q, peak_acc_n;
  logic              clip_q, clip_n;
  logic [7:0]        gain_q, gain_n;
  logic [31:0]       peak_n;
  logic              locked_n;

  logic [31:0]       mag;
  logic [31:0]       peak_max;
  logic signed [8:0] gain9, dec9, inc9;
  logic [7:0]        gain_dn, gain_up;
  logic              at_min, at_max;
  logic              in_band;

  // The most negative input has no positive twin and saturates.
  always_comb begin
    mag = data_i;
    if (data_i[31]) begin
      if (data_i == 32'h8000_0000) begin
        mag = 32'h7FFF_FFFF;
      end else begin
        mag = ~data_i + 32'd1;
      end
    end
  end

  always_comb begin
    gain9    = signed'({gain_q[7], gain_q});
    dec9     = gain9 - STEP9;
    inc9     = gain9 + STEP9;
    gain_dn  = (dec9 < MIN9) ? 8'(MIN9) : dec9[7:0];
    gain_up  = (inc9 > MAX9) ? 8'(MAX9) : inc9[7:0];
    at_min   = (gain9 <= MIN9);
    at_max   = (gain9 >= MAX9);
    peak_max = (mag > peak_acc_q) ? mag : peak_acc_q;
    in_band  = (peak_acc_q >= LOW_THRESH) && (peak_acc_q <= HIGH_THRESH);
  end

  always_comb begin
    state_n    = state_q;
    cnt_n      = cnt_q;
    peak_acc_n = peak_acc_q;
    clip_n     = 1'b0;
    gain_n     = gain_q;
    peak_n     = peak_o;
    locked_n   = locked_o;

    case (state_q)
      ST_REQUEST: begin
        state_n = ST_WAIT_BUSY;
      end

      ST_WAIT_BUSY: begin
        if (!afe_busy_i) begin
          cnt_n   = '0;
          state_n = en_i ? ST_SETTLE : ST_HOLD;
        end
      end

      ST_SETTLE: begin
        if (!en_i) begin
          state_n = ST_HOLD;
        end else if (valid_i) begin
          if (cnt_q == SET_LAST) begin
            cnt_n      = '0;
            peak_acc_n = '0;
            state_n    = ST_MEASURE;
          end else begin
            cnt_n = cnt_q + 1'b1;
          end
        end
      end

      ST_MEASURE: begin
        if (!en_i) begin
          state_n = ST_HOLD;
        end else if (valid_i) begin
          cnt_n      = cnt_q + 1'b1;
          peak_acc_n = peak_max;
          if ((mag >= CLIP_THRESH) && !at_min) begin
            clip_n     = 1'b1;
            peak_acc_n = mag;
            state_n    = ST_DECIDE;
          end else if (cnt_q == WIN_LAST) begin
            state_n = ST_DECIDE;
          end
        end
      end

      // One-cycle decision stage; a strobe landing here is not part of any window.
      ST_DECIDE: begin
        peak_n = peak_acc_q;
        if (clip_q) begin
          gain_n   = gain_dn;
          locked_n = 1'b0;
          state_n  = ST_REQUEST;
        end else if ((peak_acc_q > HIGH_THRESH) && !at_min) begin
          gain_n   = gain_dn;
          locked_n = 1'b0;
          state_n  = ST_REQUEST;
        end else if ((peak_acc_q < LOW_THRESH) && !at_max) begin
          gain_n   = gain_up;
          locked_n = 1'b0;
          state_n  = ST_REQUEST;
        end else begin
          locked_n   = in_band;
          cnt_n      = '0;
          peak_acc_n = '0;
          state_n    = ST_MEASURE;
        end
      end

      ST_HOLD: begin
        if (en_i) begin
          cnt_n   = '0;
          state_n = ST_SETTLE;
        end
      end

      default: begin
        state_n = ST_REQUEST;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_REQUEST;
      cnt_q      <= '0;
      peak_acc_q <= '0;
      clip_q     <= 1'b0;
      gain_q     <= INIT8;
      peak_o     <= '0;
      locked_o   <= 1'b0;
    end else begin
      state_q    <= state_n;
      cnt_q      <= cnt_n;
      peak_acc_q <= peak_acc_n;
      clip_q     <= clip_n;
      gain_q     <= gain_n;
      peak_o     <= peak_n;
      locked_o   <= locked_n;
    end
  end

  assign gain_dB_o  = gain_q;
  assign set_gain_o = (state_q == ST_REQUEST) && !rst;

endmodule
